// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt latch/mask/priority and trap entry/return sequencer
module irq_sequencer #(
    parameter int          NSRC         = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'd4,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NSRC-1:0] irq_in,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic [31:0]     pc_m,
    input  logic            valid_m,
    input  logic            mret_m,
    output logic            int_flush,
    output logic            int_sel,
    output logic [31:0]     pc_int,
    output logic [31:0]     mepc,
    output logic [31:0]     mcause,
    output logic            in_handler,
    output logic [NSRC-1:0] irq_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER,
        S_RETURN
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] irq_q, irq_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] ack_q, ack_d;
    logic [31:0]     mepc_q, mepc_d;
    logic [31:0]     mcause_q, mcause_d;
    logic [2:0]      flush_cnt_q, flush_cnt_d;

    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] win_oh;
    logic [3:0]      win_id;
    logic            take;

    // Descending scan so the lowest-index eligible source is the last one written.
    always_comb begin
        eligible = pending_q & mask_q;
        win_id   = 4'd0;
        win_oh   = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id    = 4'(i);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
        end
        take = (state_q == S_IDLE) && (|eligible) && valid_m;
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        ack_d       = '0;
        irq_d       = irq_in;
        // Clear applied before set so a same-cycle new edge keeps the request pending.
        pending_d   = (pending_q & ~(take ? win_oh : '0)) | (irq_in & ~irq_q);
        mask_d      = mask_we ? mask_wdata : mask_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    mepc_d      = pc_m;
                    mcause_d    = {1'b1, 27'b0, win_id};
                    ack_d       = win_oh;
                    flush_cnt_d = 3'(FLUSH_CYCLES - 1);
                    state_d     = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == 3'd0) begin
                    state_d = S_REDIRECT;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end
            S_REDIRECT: state_d = S_HANDLER;
            S_HANDLER: begin
                if (mret_m && valid_m) begin
                    state_d = S_RETURN;
                end
            end
            S_RETURN: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        int_flush  = 1'b0;
        int_sel    = 1'b0;
        pc_int     = 32'd0;
        in_handler = 1'b0;
        case (state_q)
            S_FLUSH:    int_flush = 1'b1;
            S_REDIRECT: begin
                int_sel = 1'b1;
                pc_int  = HANDLER_ADDR;
            end
            S_HANDLER:  in_handler = 1'b1;
            S_RETURN: begin
                int_flush = 1'b1;
                int_sel   = 1'b1;
                pc_int    = mepc_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            irq_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '1;
            ack_q       <= '0;
            mepc_q      <= 32'd0;
            mcause_q    <= 32'd0;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            ack_q       <= ack_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mepc    = mepc_q;
    assign mcause  = mcause_q;
    assign irq_ack = ack_q;

endmodule
